alu_md: RTL and testbench

Parametrised execute-stage ALU for the pipelined MIPS datapath, extending the single-cycle ALU with more operations and a signed-overflow flag. Adds a multi-cycle multiply/divide unit with architectural HI/LO registers, start/busy handshake and reset-safe abort. The combinational result feeds the EX/MEM register. The hazard unit stalls on `busy` for MFHI/MFLO and for new MD ops.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_md_unit.sv | 116 +++++++++++
 rtl/alu_md.sv | 78 +++++++
 tb/tb_alu_md.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and the multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_OR    = 4'd2;
  localparam logic [3:0] ALU_PASSB = 4'd3;
  localparam logic [3:0] ALU_PASSA = 4'd4;
  localparam logic [3:0] ALU_SEXTB = 4'd5;
  localparam logic [3:0] ALU_AND   = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_NOR   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_SLTU  = 4'd10;
  localparam logic [3:0] ALU_SLL   = 4'd11;
  localparam logic [3:0] ALU_SRL   = 4'd12;
  localparam logic [3:0] ALU_SRA   = 4'd13;
  localparam logic [3:0] ALU_LUI   = 4'd14;
  localparam logic [3:0] ALU_ZERO  = 4'd15;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_NOP7  = 3'd7;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  function automatic int sa_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// state | meaning
// IDLE  | accepts MULT/MULTU/DIV/DIVU (loads counter) and MTHI/MTLO
// RUN   | counter decrements; at 1, HI/LO are written and unit returns to IDLE
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);

  md_state_t        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sgn, op_div;
  logic             idle_start, is_arith, done;

  assign idle_start = md_start && (state == MD_IDLE);
  assign is_arith   = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                      (md_op == MD_DIV)  || (md_op == MD_DIVU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (idle_start && is_arith) state_nxt = MD_RUN;
      MD_RUN:  if (cnt == CW'(1)) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_RUN);
    done = (state == MD_RUN) && (cnt == CW'(1));
  end

  // Results are formed from the latched operands so A/B may change during RUN.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, q_mag, r_mag, quo, rem;

  always_comb begin
    ext_a = op_sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b = op_sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    prod  = ext_a * ext_b;
    a_neg = op_sgn && op_a[WIDTH-1];
    b_neg = op_sgn && op_b[WIDTH-1];
    mag_a = a_neg ? -op_a : op_a;
    mag_b = b_neg ? -op_b : op_b;
    q_mag = (mag_b == '0) ? '0 : mag_a / mag_b;
    r_mag = (mag_b == '0) ? '0 : mag_a % mag_b;
    // MIN/-1 falls out naturally: |MIN| as unsigned negates back to MIN.
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sgn <= 1'b0;
      op_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == MD_IDLE) begin
      if (idle_start) begin
        case (md_op)
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            op_a   <= a;
            op_b   <= b;
            op_sgn <= (md_op == MD_MULT) || (md_op == MD_DIV);
            op_div <= (md_op == MD_DIV)  || (md_op == MD_DIVU);
            cnt    <= ((md_op == MD_DIV) || (md_op == MD_DIVU)) ? CW'(DIV_LAT) : CW'(MUL_LAT);
          end
          MD_MTHI: hi <= a;
          MD_MTLO: lo <= a;
          default: ;
        endcase
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (done) begin
        if (!op_div) begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end else if (op_b == '0) begin
          hi <= op_a;
          lo <= '1;
        end else begin
          hi <= rem;
          lo <= quo;
        end
      end
    end
  end

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU with signed-overflow flag, plus the multiply/divide unit.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             ovf,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SAW    = sa_width(WIDTH);
  localparam int LUI_SH = (WIDTH > 16) ? WIDTH - 16 : 0;

  logic [SAW-1:0]   sa;
  logic [WIDTH-1:0] sum, diff;

  assign sa   = A[SAW-1:0];
  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    ALU_Out = '0;
    ovf     = 1'b0;
    case (ALUOp)
      ALU_ADD: begin
        ALU_Out = sum;
        ovf     = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        ALU_Out = diff;
        ovf     = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_OR:    ALU_Out = A | B;
      ALU_PASSB: ALU_Out = B;
      ALU_PASSA: ALU_Out = A;
      ALU_SEXTB: ALU_Out = WIDTH'($signed(B[7:0]));
      ALU_AND:   ALU_Out = A & B;
      ALU_XOR:   ALU_Out = A ^ B;
      ALU_NOR:   ALU_Out = ~(A | B);
      ALU_SLT:   ALU_Out = WIDTH'($signed(A) < $signed(B));
      ALU_SLTU:  ALU_Out = WIDTH'(A < B);
      ALU_SLL:   ALU_Out = B << sa;
      ALU_SRL:   ALU_Out = B >> sa;
      ALU_SRA:   ALU_Out = $signed(B) >>> sa;
      ALU_LUI:   ALU_Out = B << LUI_SH;
      default:   ALU_Out = '0;
    endcase
  end

  md_unit #(
    .WIDTH  (WIDTH),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_md (
    .clk     (clk),
    .reset   (reset),
    .a       (A),
    .b       (B),
    .md_op   (md_op),
    .md_start(md_start),
    .busy    (busy),
    .hi      (HI),
    .lo      (LO)
  );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: arithmetic reference model plus directed literal vectors.
module tb_alu_md;
  import alu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  ALUOp;
  logic [2:0]  md_op;
  logic        md_start;
  logic [31:0] ALU_Out, HI, LO;
  logic        ovf, busy;

  alu_md #(.WIDTH(32), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ALUOp(ALUOp), .ALU_Out(ALU_Out),
    .ovf(ovf), .md_op(md_op), .md_start(md_start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ALU reference: {ovf, result} from plain integer arithmetic.
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa_ = $signed(a);
    longint sb_ = $signed(b);
    longint s;
    logic [4:0]  sh = a[4:0];
    logic [31:0] r  = 32'h0;
    logic        ov = 1'b0;
    case (op)
      4'd0:  begin s = sa_ + sb_; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1:  begin s = sa_ - sb_; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2:  r = a | b;
      4'd3:  r = b;
      4'd4:  r = a;
      4'd5:  r = {{24{b[7]}}, b[7:0]};
      4'd6:  r = a & b;
      4'd7:  r = a ^ b;
      4'd8:  r = ~(a | b);
      4'd9:  r = (sa_ < sb_) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: r = b << sh;
      4'd12: r = b >> sh;
      4'd13: r = 32'($signed(b) >>> sh);
      4'd14: r = {b[15:0], 16'h0};
      default: r = 32'h0;
    endcase
    return {ov, r};
  endfunction

  // MD reference: {HI, LO} from 64-bit integer arithmetic.
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x = $signed(a);
    longint y = $signed(b);
    longint q, r;
    logic [63:0] u;
    case (op)
      3'd1: begin q = x * y; return q; end
      3'd2: begin u = {32'h0, a} * {32'h0, b}; return u; end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q = x / y; r = x % y;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_rem;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= 32'h0; m_lo <= 32'h0; m_rem <= 0; m_pend <= 64'h0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (md_start) begin
      case (md_op)
        3'd1, 3'd2: begin m_pend <= md_ref(md_op, A, B); m_rem <= ML; end
        3'd3, 3'd4: begin m_pend <= md_ref(md_op, A, B); m_rem <= DL; end
        3'd5: m_hi <= A;
        3'd6: m_lo <= A;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      e = alu_ref(ALUOp, A, B);
      check("alu_out", ALU_Out, e[31:0]);
      check("ovf", ovf, e[32]);
      check("busy", busy, m_rem > 0);
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end
  end

  task automatic alu_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic eo);
    @(posedge clk); #2;
    ALUOp = op; A = a; B = b;
    #1;
    check({name, "_out"}, ALU_Out, er);
    check({name, "_ovf"}, ovf, eo);
  endtask

  task automatic md_go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    md_op = op; A = a; B = b; md_start = 1'b1;
    @(posedge clk); #2;
    md_start = 1'b0; md_op = MD_NOP;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 100) begin
        errors++;
        $display("FAIL md_timeout: busy still high after %0d cycles, required low", n);
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic [31:0] va [4] = '{32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] vb [4] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'hF0F0_0F81, 32'h8000_0000};

    reset = 1'b1; A = '0; B = '0; ALUOp = '0; md_op = '0; md_start = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    @(posedge clk); #3 reset = 1'b0;

    alu_vec("add_ovf",  ALU_ADD,   32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b1);
    alu_vec("sub_ovf",  ALU_SUB,   32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 1'b1);
    alu_vec("sub_ok",   ALU_SUB,   32'h5,         32'h7,          32'hFFFF_FFFE, 1'b0);
    alu_vec("sextb",    ALU_SEXTB, 32'h0,         32'h0000_00F0,  32'hFFFF_FFF0, 1'b0);
    alu_vec("sra",      ALU_SRA,   32'h4,         32'h8000_0000,  32'hF800_0000, 1'b0);
    alu_vec("slt",      ALU_SLT,   32'hFFFF_FFFF, 32'h1,          32'h1,         1'b0);
    alu_vec("sltu",     ALU_SLTU,  32'hFFFF_FFFF, 32'h1,          32'h0,         1'b0);
    alu_vec("sll_hi_a", ALU_SLL,   32'hFFFF_FFE3, 32'h1,          32'h8,         1'b0);
    alu_vec("lui",      ALU_LUI,   32'h0,         32'hABCD_1234,  32'h1234_0000, 1'b0);
    alu_vec("zero",     ALU_ZERO,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0,         1'b0);

    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #2;
        ALUOp = 4'(op); A = va[k]; B = vb[k];
      end
    end
    @(posedge clk); #2 ALUOp = ALU_ADD;

    md_go(MD_MULT, 32'hFFFF_FFFE, 32'h3);
    wait_idle(n);
    check("mult_busy_cycles", n, ML);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    md_go(MD_MULTU, 32'hFFFF_FFFE, 32'h3);
    wait_idle(n);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    md_go(MD_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_idle(n);
    check("div_busy_cycles", n, DL);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    md_go(MD_DIVU, 32'h7, 32'h0);
    wait_idle(n);
    check("divz_lo", LO, 32'hFFFF_FFFF);
    check("divz_hi", HI, 32'h7);

    md_go(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divmin_lo", LO, 32'h8000_0000);
    check("divmin_hi", HI, 32'h0);

    // Starts during busy, including one in the completion cycle, must be ignored.
    md_go(MD_DIV, 32'd100, 32'd7);
    for (int k = 1; k <= DL; k++) begin
      md_start = (k == 2) || (k == 5) || (k == DL);
      md_op    = (k == 2) ? MD_MTLO : (k == 5) ? MD_MULT : MD_MTHI;
      A = 32'h55 + 32'(k); B = 32'h3;
      @(posedge clk); #2;
    end
    md_start = 1'b0; md_op = MD_NOP;
    check("ign_busy", busy, 1'b0);
    check("ign_lo", LO, 32'd14);
    check("ign_hi", HI, 32'd2);

    md_go(MD_MTHI, 32'h1234, 32'h0);
    check("mthi_hi", HI, 32'h1234);
    check("mthi_busy", busy, 1'b0);
    md_go(MD_MTLO, 32'hABCD, 32'h0);
    check("mtlo_lo", LO, 32'hABCD);

    md_go(MD_DIV, 32'd50, 32'd3);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    @(posedge clk); #3 reset = 1'b0;

    md_go(MD_MULT, 32'd3, 32'd5);
    wait_idle(n);
    check("post_rst_cycles", n, ML);
    check("post_rst_lo", LO, 32'd15);
    check("post_rst_hi", HI, 32'd0);

    repeat (DL + 2) @(posedge clk);
    #2;
    check("no_stale_lo", LO, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
